pipeline_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB latches plus PC). It replaces the per-latch ihit-tied enables and the hardwired zero flushes with prioritised, per-stage enable and flush controls. Sources are cache hits, load-use hazards, control redirects resolved in EX/MEM, and halt. A small FSM tracks data-memory waits and halt, and two saturating counters record stall and redirect activity for performance debug.

---
 rtl/pipeline_hazard_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: prioritised per-stage
// load enables and bubble flushes, a RUN/DWAIT/HALT tracker and debug counters.
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 32,
    parameter int REG_W = 5
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [REG_W-1:0] fd_rs1,
    input  logic [REG_W-1:0] fd_rs2,
    input  logic             fd_uses_rs1,
    input  logic             fd_uses_rs2,
    input  logic             dx_dREN,
    input  logic [REG_W-1:0] dx_rd,
    input  logic             xm_dREN,
    input  logic             xm_dWEN,
    input  logic             xm_redirect,
    input  logic             mw_halt,
    output logic             pc_en,
    output logic             fd_en,
    output logic             dx_en,
    output logic             xm_en,
    output logic             mw_en,
    output logic             fd_flush,
    output logic             dx_flush,
    output logic             xm_flush,
    output logic             mw_flush,
    output logic             halt,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam logic [1:0]       ST_RUN   = 2'd0;
    localparam logic [1:0]       ST_DWAIT = 2'd1;
    localparam logic [1:0]       ST_HALT  = 2'd2;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic             r_halt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_redirect_cnt;

    logic w_mem;
    logic w_lu;
    logic w_redirect_take;
    logic w_stall_inc;

    assign w_mem = xm_dREN | xm_dWEN;
    assign w_lu  = dx_dREN && (dx_rd != '0) &&
                   ((fd_uses_rs1 && (fd_rs1 == dx_rd)) ||
                    (fd_uses_rs2 && (fd_rs2 == dx_rd)));

    // State register.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: halt beats everything and is sticky until reset.
    always_comb begin
        w_next_state = r_state;
        if (mw_halt) begin
            w_next_state = ST_HALT;
        end else begin
            case (r_state)
                ST_RUN:   if (w_mem && !dhit) w_next_state = ST_DWAIT;
                ST_DWAIT: if (dhit) w_next_state = ST_RUN;
                ST_HALT:  w_next_state = ST_HALT;
                default:  w_next_state = ST_RUN;
            endcase
        end
    end

    // Enable/flush contract: a latch loads when its *_en is high; when *_flush is
    // also high it loads a bubble instead. Flush is never raised without enable.
    always_comb begin
        pc_en           = 1'b0;
        fd_en           = 1'b0;
        dx_en           = 1'b0;
        xm_en           = 1'b0;
        mw_en           = 1'b0;
        fd_flush        = 1'b0;
        dx_flush        = 1'b0;
        xm_flush        = 1'b0;
        w_redirect_take = 1'b0;
        if (nRST && (r_state != ST_HALT) && !(w_mem && !dhit)) begin
            if (w_mem && !ihit) begin
                // Load data is captured in MEM/WB; EX/MEM gets a bubble so the
                // access is not re-issued while fetch is still stalled.
                xm_en    = 1'b1;
                xm_flush = 1'b1;
                mw_en    = 1'b1;
            end else if (xm_redirect) begin
                w_redirect_take = 1'b1;
                pc_en    = 1'b1;
                fd_en    = 1'b1;
                dx_en    = 1'b1;
                xm_en    = 1'b1;
                mw_en    = 1'b1;
                fd_flush = 1'b1;
                dx_flush = 1'b1;
                xm_flush = 1'b1;
            end else if (w_lu) begin
                dx_en    = 1'b1;
                dx_flush = 1'b1;
                xm_en    = 1'b1;
                mw_en    = 1'b1;
            end else if (!ihit) begin
                fd_en    = 1'b1;
                fd_flush = 1'b1;
                dx_en    = 1'b1;
                xm_en    = 1'b1;
                mw_en    = 1'b1;
            end else begin
                pc_en    = 1'b1;
                fd_en    = 1'b1;
                dx_en    = 1'b1;
                xm_en    = 1'b1;
                mw_en    = 1'b1;
            end
        end
    end

    assign mw_flush    = 1'b0;
    assign w_stall_inc = (r_state != ST_HALT) && !pc_en;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_halt         <= 1'b0;
            r_stall_cnt    <= '0;
            r_redirect_cnt <= '0;
        end else begin
            r_halt <= (w_next_state == ST_HALT);
            if (w_stall_inc && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (w_redirect_take && (r_redirect_cnt != CNT_MAX)) begin
                r_redirect_cnt <= r_redirect_cnt + CNT_ONE;
            end
        end
    end

    assign halt         = r_halt;
    assign state_o      = r_state;
    assign stall_cnt    = r_stall_cnt;
    assign redirect_cnt = r_redirect_cnt;

endmodule
